// File: rtl/xs_jtag_pkg.sv
// Shared types and helpers for the JTAG TAP responder: 1149.1 state encoding,
// default opcodes and the TMS-driven next-state function.
package xs_jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_e;

   localparam int          DEF_IR_WIDTH      = 5;
   localparam int          DEF_USER_DR_WIDTH = 41;
   localparam int          IDCODE_WIDTH      = 32;
   localparam logic [31:0] DEF_IDCODE_VALUE  = 32'h1000_0A6D;
   localparam logic [4:0]  DEF_IR_IDCODE     = 5'h01;
   localparam logic [4:0]  DEF_IR_USER       = 5'h11;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic tap_state_e tap_next_state(input tap_state_e cur, input logic tms);
      tap_state_e nxt;
      case (cur)
         TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          nxt = TEST_LOGIC_RESET;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/xs_jtag_tap_fsm.sv
// 16-state TAP controller; advances on detected TCK rises, forced to
// Test-Logic-Reset by TRSTn regardless of any coincident edge.
module xs_jtag_tap_fsm
   import xs_jtag_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       rise,
   input  logic       tms,
   input  logic       trst_n,
   output tap_state_e state
);

   tap_state_e state_r;
   tap_state_e state_nxt_s;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= TEST_LOGIC_RESET;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state selection: TRSTn beats any edge
   always_comb begin
      state_nxt_s = state_r;
      if (!trst_n) begin
         state_nxt_s = TEST_LOGIC_RESET;
      end else if (rise) begin
         state_nxt_s = tap_next_state(state_r, tms);
      end else begin
         state_nxt_s = state_r;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/xs_jtag_tap_responder.sv
// Target-side JTAG TAP in the system clock domain: IR plus IDCODE, BYPASS
// and USER data registers sharing one shift register; all outputs registered.
module xs_jtag_tap_responder
   import xs_jtag_pkg::*;
#(
   parameter int                     IR_WIDTH      = DEF_IR_WIDTH,
   parameter logic [31:0]            IDCODE_VALUE  = DEF_IDCODE_VALUE,
   parameter int                     USER_DR_WIDTH = DEF_USER_DR_WIDTH,
   parameter logic [IR_WIDTH-1:0]    IR_IDCODE     = DEF_IR_IDCODE,
   parameter logic [IR_WIDTH-1:0]    IR_USER       = DEF_IR_USER
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      jtag_TCK,
   input  logic                      jtag_TMS,
   input  logic                      jtag_TDI,
   input  logic                      jtag_TRSTn,
   output logic                      jtag_TDO_data,
   output logic                      jtag_TDO_driven,
   input  logic [USER_DR_WIDTH-1:0]  user_capture_data,
   output logic                      user_capture_strobe,
   output logic                      user_update_valid,
   output logic [USER_DR_WIDTH-1:0]  user_update_data,
   output logic [3:0]                tap_state
);

   localparam int SR_WIDTH = max_int(max_int(IDCODE_WIDTH, USER_DR_WIDTH), IR_WIDTH);
   localparam int IDX_W    = $clog2(SR_WIDTH);

   logic                     tck_q_r;
   logic                     rise_s;
   logic                     fall_s;
   tap_state_e               state_s;
   tap_state_e               next_state_s;
   logic [IR_WIDTH-1:0]      ir_r;
   logic [SR_WIDTH-1:0]      shift_r;
   logic [SR_WIDTH-1:0]      shift_next_s;
   logic [SR_WIDTH-1:0]      capture_dr_s;
   logic [IDX_W-1:0]         ins_idx_s;
   dr_sel_e                  dr_sel_s;
   logic                     tdo_data_r;
   logic                     tdo_driven_r;
   logic                     capture_strobe_r;
   logic                     update_valid_r;
   logic [USER_DR_WIDTH-1:0] update_data_r;

   assign rise_s       = !tck_q_r && jtag_TCK;
   assign fall_s       = tck_q_r && !jtag_TCK;
   assign next_state_s = tap_next_state(state_s, jtag_TMS);

   xs_jtag_tap_fsm u_fsm (
      .clock  (clock),
      .reset  (reset),
      .rise   (rise_s),
      .tms    (jtag_TMS),
      .trst_n (jtag_TRSTn),
      .state  (state_s)
   );

   // Data register selection and the value it captures
   always_comb begin
      dr_sel_s     = DR_BYPASS;
      capture_dr_s = {SR_WIDTH{1'b0}};
      if (ir_r == IR_IDCODE) begin
         dr_sel_s     = DR_IDCODE;
         capture_dr_s = SR_WIDTH'(IDCODE_VALUE);
      end else if (ir_r == IR_USER) begin
         dr_sel_s     = DR_USER;
         capture_dr_s = SR_WIDTH'(user_capture_data);
      end else begin
         dr_sel_s     = DR_BYPASS;
         capture_dr_s = {SR_WIDTH{1'b0}};
      end
   end

   // TDI enters at the MSB of whichever register is currently active
   always_comb begin
      ins_idx_s = {IDX_W{1'b0}};
      if (state_s == SHIFT_IR) begin
         ins_idx_s = IDX_W'(IR_WIDTH - 1);
      end else begin
         case (dr_sel_s)
            DR_IDCODE: ins_idx_s = IDX_W'(IDCODE_WIDTH - 1);
            DR_USER:   ins_idx_s = IDX_W'(USER_DR_WIDTH - 1);
            default:   ins_idx_s = {IDX_W{1'b0}};
         endcase
      end
      shift_next_s            = {1'b0, shift_r[SR_WIDTH-1:1]};
      shift_next_s[ins_idx_s] = jtag_TDI;
   end

   // Edge tracking, capture/shift on rise, update and TDO on fall
   always_ff @(posedge clock) begin
      if (reset) begin
         tck_q_r          <= 1'b0;
         ir_r             <= IR_IDCODE;
         shift_r          <= {SR_WIDTH{1'b0}};
         tdo_data_r       <= 1'b0;
         tdo_driven_r     <= 1'b0;
         capture_strobe_r <= 1'b0;
         update_valid_r   <= 1'b0;
         update_data_r    <= {USER_DR_WIDTH{1'b0}};
      end else begin
         tck_q_r          <= jtag_TCK;
         capture_strobe_r <= 1'b0;
         update_valid_r   <= 1'b0;
         if (!jtag_TRSTn) begin
            ir_r         <= IR_IDCODE;
            tdo_driven_r <= 1'b0;
         end else if (rise_s) begin
            case (state_s)
               CAPTURE_IR: shift_r <= {{(SR_WIDTH-2){1'b0}}, 2'b01};
               SHIFT_IR:   shift_r <= shift_next_s;
               CAPTURE_DR: begin
                  shift_r          <= capture_dr_s;
                  capture_strobe_r <= (dr_sel_s == DR_USER);
               end
               SHIFT_DR:   shift_r <= shift_next_s;
               default:    shift_r <= shift_r;
            endcase
            if (next_state_s == TEST_LOGIC_RESET) begin
               ir_r <= IR_IDCODE;
            end
         end else if (fall_s) begin
            if (state_s == SHIFT_IR || state_s == SHIFT_DR) begin
               tdo_data_r   <= shift_r[0];
               tdo_driven_r <= 1'b1;
            end else begin
               tdo_driven_r <= 1'b0;
            end
            if (state_s == UPDATE_IR) begin
               ir_r <= shift_r[IR_WIDTH-1:0];
            end
            if (state_s == UPDATE_DR && dr_sel_s == DR_USER) begin
               update_data_r  <= shift_r[USER_DR_WIDTH-1:0];
               update_valid_r <= 1'b1;
            end
         end
      end
   end

   assign jtag_TDO_data       = tdo_data_r;
   assign jtag_TDO_driven     = tdo_driven_r;
   assign user_capture_strobe = capture_strobe_r;
   assign user_update_valid   = update_valid_r;
   assign user_update_data    = update_data_r;
   assign tap_state           = state_s;

endmodule

// File: doc/xs_jtag_tap_responder.md
Name: xs_jtag_tap_responder

Overview:
- Target-side JTAG TAP that consumes the bit-banged TCK/TMS/TDI/TRSTn produced by the DPI top and returns TDO data and TDO-driven.
- Runs entirely in the system clock domain. TCK is treated as a sampled level and edge-detected.
- Implements the IEEE 1149.1 16-state TAP controller, an instruction register, and the IDCODE, BYPASS and USER data registers.
- The USER register exchanges data with the debug module through capture and update strobes.

Parameters:
- IR_WIDTH, 5, instruction register width (min 2).
- IDCODE_VALUE, 32'h1000_0A6D, value captured by IDCODE (bit 0 must be 1).
- USER_DR_WIDTH, 41, USER data register width.
- IR_IDCODE, 5'h01, IDCODE opcode.
- IR_USER, 5'h11, USER opcode.
- BYPASS is all-ones. Any unlisted opcode also selects BYPASS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jtag_TCK  in  1  bit-banged TCK level, synchronous to clock
- jtag_TMS  in  1  TMS
- jtag_TDI  in  1  TDI
- jtag_TRSTn  in  1  TAP reset, active-low, sampled on clock
- jtag_TDO_data  out  1  TDO bit
- jtag_TDO_driven  out  1  1 while TDO is valid (Shift-IR/Shift-DR)
- user_capture_data  in  USER_DR_WIDTH  value loaded on USER Capture-DR
- user_capture_strobe  out  1  one-clock pulse on USER Capture-DR
- user_update_valid  out  1  one-clock pulse on USER Update-DR
- user_update_data  out  USER_DR_WIDTH  shifted-in USER value; held until the next update
- tap_state  out  4  current TAP state, debug only

Behaviour:
- Reset (reset=1) values:
  - tap_state=TEST_LOGIC_RESET, IR=IR_IDCODE, tck_q=0.
  - TDO_data=0, TDO_driven=0.
  - Both strobes 0, user_update_data=0.
- Edge detection: tck_q holds the previous jtag_TCK.
  - rise = !tck_q & jtag_TCK.
  - fall = tck_q & !jtag_TCK.
  - At most one edge per clock.
- Priority, highest first: reset, then jtag_TRSTn==0, then edges.
  - TRSTn==0 on any clock forces TEST_LOGIC_RESET, IR=IR_IDCODE and TDO_driven=0.
  - This holds even if an edge occurs in the same clock.
- On rise: the state advances per the standard 1149.1 TMS transition table.
- Register actions on rise, keyed on the state before the transition:
  - CAPTURE_IR: IR shift reg = {0..0,2'b01}.
  - SHIFT_IR: shift right, TDI into MSB.
  - CAPTURE_DR: load the selected DR.
    - IDCODE loads IDCODE_VALUE.
    - BYPASS loads 1'b0.
    - USER loads user_capture_data and pulses user_capture_strobe the next clock.
  - SHIFT_DR: shift right with TDI into the MSB of the selected DR width.
- Update actions on fall, while in the state:
  - UPDATE_IR: IR = IR shift reg.
  - UPDATE_DR with IR=IR_USER: user_update_data = DR shift reg, and user_update_valid pulses for exactly one clock.
  - A single fall yields only one pulse, regardless of how long the state is held.
- TDO on fall:
  - In SHIFT_IR or SHIFT_DR: TDO_data = shift_reg[0] and TDO_driven=1.
  - In any other state: TDO_driven=0 and TDO_data holds its last value.
  - After the first rise in a shift state, the bits seen are reg[0], reg[1], … (LSB first).
- Shift register: one register of width max(32, USER_DR_WIDTH, IR_WIDTH), with the MSB insertion point selected by the active register length.
- Five consecutive rises with TMS=1 reach TEST_LOGIC_RESET from any state.
- Entering TEST_LOGIC_RESET by TMS sets IR=IR_IDCODE on that rise.
- No combinational path from inputs to outputs. All outputs are registered.
- Latency: responses follow the triggering TCK edge by 1 clock.

Decomposition:
- Package xs_jtag_pkg holds:
  - tap_state_e, a 4-bit enum using the 1149.1 encoding (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D).
  - The default opcode constants.
  - The next-state function.
- One sub-module, xs_jtag_tap_fsm: takes rise, TMS and TRSTn, and outputs the state.
- Register and shift logic stays in the top module.

Test Plan:
- reset=1 for 2 clocks, then TMS=1 with 5 TCK pulses -> tap_state=F, TDO_driven=0, IR=01.
- From reset, go to Shift-DR and shift 32 bits with TDI=0 -> TDO stream LSB-first = 0x10000A6D, TDO_driven=1 only during the shift.
- Capture-IR, then shift 5 bits with TDI=1 -> TDO reads 1,0,0,0,0. Update-IR leaves IR=1F (BYPASS). Then shift DR with TDI pattern 1,0,1 -> TDO shows 0,1,0 (1-bit delay).
- Load IR=11, user_capture_data=41'h1_2345_6789A, run a DR scan shifting in 41'h0_DEAD_BEEF0 -> capture_strobe pulses once, TDO yields 0x123456789A LSB-first, user_update_valid pulses once with data 0x0DEADBEEF0.
- Mid-way through a USER Shift-DR, drive jtag_TRSTn=0 for 1 clock coincident with a TCK rise -> tap_state=F next clock, IR=01, no update pulse, TDO_driven=0.
- Hold TCK high for 10 clocks in Update-DR -> exactly one user_update_valid pulse.
